// File: rtl/hlsm_host_driver.sv
// Host-side initiator for the HLSM Start/Done protocol: accepts an operand set,
// pulses Start, waits for Done (with a watchdog) and returns the captured outputs.
module hlsm_host_driver #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [WIDTH-1:0] req_c,
   input  logic             req_t,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_z,
   output logic [WIDTH-1:0] rsp_x,
   output logic             rsp_timeout,
   output logic             hlsm_start,
   output logic [WIDTH-1:0] hlsm_a,
   output logic [WIDTH-1:0] hlsm_b,
   output logic [WIDTH-1:0] hlsm_c,
   output logic [WIDTH-1:0] hlsm_zero,
   output logic [WIDTH-1:0] hlsm_one,
   output logic             hlsm_t,
   input  logic             hlsm_done,
   input  logic [WIDTH-1:0] hlsm_z,
   input  logic [WIDTH-1:0] hlsm_x,
   output logic             busy,
   output logic [CNT_W-1:0] txn_count
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e           state_q;
   logic [TW-1:0]    timer_q;
   logic [TW-1:0]    timer_d;
   logic [CNT_W-1:0] txnCnt_q;
   logic [CNT_W-1:0] txnCnt_d;
   logic             timeoutHit;
   logic             start_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [WIDTH-1:0] opC_q;
   logic             opT_q;
   logic             rspValid_q;
   logic [WIDTH-1:0] rspZ_q;
   logic [WIDTH-1:0] rspX_q;
   logic             rspTimeout_q;

   // The watchdog fires on the WAIT cycle whose timer holds TIMEOUT-1, giving
   // exactly TIMEOUT WAIT cycles in which a Done is still honoured.
   always_comb begin
      timer_d    = timer_q + TW'(1);
      txnCnt_d   = txnCnt_q + CNT_W'(1);
      timeoutHit = (timer_q == TW'(TIMEOUT - 1));
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         txnCnt_q     <= '0;
         start_q      <= 1'b0;
         opA_q        <= '0;
         opB_q        <= '0;
         opC_q        <= '0;
         opT_q        <= 1'b0;
         rspValid_q   <= 1'b0;
         rspZ_q       <= '0;
         rspX_q       <= '0;
         rspTimeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready) begin
                  opA_q   <= req_a;
                  opB_q   <= req_b;
                  opC_q   <= req_c;
                  opT_q   <= req_t;
                  start_q <= 1'b1;
                  state_q <= START;
               end
            end
            START: begin
               start_q <= 1'b0;
               timer_q <= '0;
               state_q <= WAIT;
            end
            // Done takes priority over the watchdog on the boundary cycle.
            WAIT: begin
               if (hlsm_done) begin
                  rspZ_q       <= hlsm_z;
                  rspX_q       <= hlsm_x;
                  rspTimeout_q <= 1'b0;
                  rspValid_q   <= 1'b1;
                  state_q      <= RESP;
               end else if (timeoutHit) begin
                  rspZ_q       <= '0;
                  rspX_q       <= '0;
                  rspTimeout_q <= 1'b1;
                  rspValid_q   <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  timer_q <= timer_d;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rspValid_q <= 1'b0;
                  txnCnt_q   <= txnCnt_d;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign hlsm_start  = start_q;
   assign hlsm_a      = opA_q;
   assign hlsm_b      = opB_q;
   assign hlsm_c      = opC_q;
   assign hlsm_t      = opT_q;
   assign hlsm_zero   = '0;
   assign hlsm_one    = WIDTH'(1);
   assign rsp_valid   = rspValid_q;
   assign rsp_z       = rspZ_q;
   assign rsp_x       = rspX_q;
   assign rsp_timeout = rspTimeout_q;
   assign txn_count   = txnCnt_q;

endmodule
